// File: rtl/ping_pong_display_scanner.sv
// Four-digit, common-anode, time-multiplexed seven-segment scanner for the
// ping-pong counter. Digits 3/2 show the tens/ones of the counter value and
// digits 1/0 show a direction arrow. The inputs are captured once per scan
// frame, so a frame never shows a torn value. The outputs are registered.
module ping_pong_display_scanner #(
  parameter int REFRESH_DIV = 131072  // clk cycles per digit, must be >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count_in,
  input  logic       dir_in,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_UP   = 7'b0011100;  // a,b,f,g lit
  localparam logic [6:0] SEG_DOWN = 7'b0100011;  // c,d,e,g lit
  localparam logic [6:0] SEG_ONE  = 7'b1111001;

  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    snap_val_q, snap_val_d;
  logic          snap_dir_q, snap_dir_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          ref_wrap;
  logic          frame_wrap;
  logic [3:0]    ones_val;
  logic [6:0]    ones_glyph;
  logic [6:0]    digit_glyph;
  logic [3:0]    an_sel;

  assign ref_wrap   = (refresh_q == REF_LAST);
  assign frame_wrap = ref_wrap && (idx_q == 2'd3);

  // Active-low one-hot digit select decoded from the current index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_an_sel
    assign an_sel[gi] = (idx_q != 2'(gi));
  end

  // Ones digit of the snapshot, 0..9, in 4-bit arithmetic.
  assign ones_val = (snap_val_q >= 4'd10) ? (snap_val_q - 4'd10) : snap_val_q;

  // Decimal glyph lookup for the ones digit.
  always_comb begin
    ones_glyph = SEG_OFF;
    case (ones_val)
      4'd0:    ones_glyph = 7'b1000000;
      4'd1:    ones_glyph = 7'b1111001;
      4'd2:    ones_glyph = 7'b0100100;
      4'd3:    ones_glyph = 7'b0110000;
      4'd4:    ones_glyph = 7'b0011001;
      4'd5:    ones_glyph = 7'b0010010;
      4'd6:    ones_glyph = 7'b0000010;
      4'd7:    ones_glyph = 7'b1111000;
      4'd8:    ones_glyph = 7'b0000000;
      4'd9:    ones_glyph = 7'b0010000;
      default: ones_glyph = SEG_OFF;
    endcase
  end

  // Pick the glyph for the digit currently selected; tens suppresses a leading zero.
  always_comb begin
    digit_glyph = SEG_OFF;
    case (idx_q)
      2'd3:    digit_glyph = (snap_val_q >= 4'd10) ? SEG_ONE : SEG_OFF;
      2'd2:    digit_glyph = ones_glyph;
      default: digit_glyph = snap_dir_q ? SEG_UP : SEG_DOWN;
    endcase
  end

  // Next state: refresh timing, digit index, frame snapshot and output image.
  always_comb begin
    refresh_d  = refresh_q + 1'b1;
    idx_d      = idx_q;
    snap_val_d = snap_val_q;
    snap_dir_d = snap_dir_q;
    an_d       = an_sel;
    seg_d      = digit_glyph;

    if (ref_wrap) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end

    // The snapshot only moves at the frame boundary, so each frame is coherent.
    if (frame_wrap) begin
      snap_val_d = count_in;
      snap_dir_d = dir_in;
    end

    if (blank) begin
      an_d  = 4'b1111;
      seg_d = SEG_OFF;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_q  <= '0;
      idx_q      <= 2'd0;
      snap_val_q <= 4'd0;
      snap_dir_q <= 1'b1;
      an_q       <= 4'b1111;
      seg_q      <= SEG_OFF;
    end else begin
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_dir_q <= snap_dir_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
